// File: rtl/om_seq_ctrl.sv
// Sequencer for a radix-2 signed-digit online multiplier stage. It holds the
// on-the-fly converted operand prefixes and the carry-save residual, and it emits product digits.

module om_seq_otf #(
  parameter int W  = 8,
  parameter int JW = 4
) (
  input  logic          en,
  input  logic [1:0]    dig,
  input  logic [JW-1:0] pos,
  input  logic [W:0]    q,
  input  logic [W:0]    qm,
  output logic [W:0]    q_nxt,
  output logic [W:0]    qm_nxt
);
  localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};
  logic [W:0] bitm;

  assign bitm = ONE << pos;

  // QM tracks Q - 2^p, so a -1 digit is a bit-set on QM rather than a borrow.
  always_comb begin
    q_nxt  = q;
    qm_nxt = qm;
    if (en) begin
      case (dig)
        2'b10:   begin q_nxt = q | bitm; qm_nxt = q; end
        2'b01:   q_nxt  = qm | bitm;
        default: qm_nxt = qm | bitm;
      endcase
    end
  end
endmodule

module om_seq_ctrl #(
  parameter int WL_XY = 8,
  parameter int DELTA = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         x_in,
  input  logic [1:0]         y_in,
  output logic [1:0]         z_out,
  output logic               z_valid,
  output logic               busy,
  output logic               done,
  output logic [1:0]         stg_x,
  output logic [1:0]         stg_y,
  output logic [WL_XY:0]     stg_xY_in,
  output logic [WL_XY:0]     stg_yX_in,
  output logic [WL_XY+3:0]   stg_Ws_in,
  output logic [WL_XY+3:0]   stg_Wc_in,
  input  logic [1:0]         stg_z,
  input  logic [WL_XY+3:0]   stg_Ws_out,
  input  logic [WL_XY+3:0]   stg_Wc_out
);
  localparam int JW = $clog2(WL_XY + DELTA + 1);
  localparam int RW = WL_XY + 4;
  localparam logic [WL_XY:0]  QM_INIT  = {1'b1, {WL_XY{1'b0}}};
  localparam logic [JW-1:0]   J_LAST_L = JW'(WL_XY - 1);
  localparam logic [JW-1:0]   J_LAST_F = JW'(WL_XY + DELTA - 1);
  localparam logic [JW-1:0]   J_DELTA  = JW'(DELTA);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [JW-1:0]           j_q, j_d;
  // lane 0 = X, lane 1 = Y
  logic [1:0][WL_XY:0]     q_q, q_d, qm_q, qm_d, q_nxt, qm_nxt;
  logic [RW-1:0]           ws_q, ws_d, wc_q, wc_d;
  logic [1:0]              z_out_q, z_out_d;
  logic                    z_valid_q, z_valid_d;
  logic                    done_q, done_d;
  logic [1:0][1:0]         dig;
  logic                    load_step, step;
  logic [JW-1:0]           pos;

  function automatic logic [1:0] san(input logic [1:0] d);
    return (d == 2'b11) ? 2'b00 : d;
  endfunction

  assign load_step = (state_q == LOAD) && in_valid;
  assign step      = load_step || (state_q == FLUSH);
  assign dig       = load_step ? {san(y_in), san(x_in)} : '0;
  assign pos       = J_LAST_L - j_q;

  generate
    for (genvar i = 0; i < 2; i++) begin : g_otf
      om_seq_otf #(.W(WL_XY), .JW(JW)) u_otf (
        .en     (load_step),
        .dig    (dig[i]),
        .pos    (pos),
        .q      (q_q[i]),
        .qm     (qm_q[i]),
        .q_nxt  (q_nxt[i]),
        .qm_nxt (qm_nxt[i])
      );
    end
  endgenerate

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign z_out     = z_out_q;
  assign z_valid   = z_valid_q;
  assign stg_x     = dig[0];
  assign stg_y     = dig[1];
  assign stg_xY_in = q_nxt[1];
  assign stg_yX_in = q_q[0];
  assign stg_Ws_in = ws_q;
  assign stg_Wc_in = wc_q;

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    q_d       = q_q;
    qm_d      = qm_q;
    ws_d      = ws_q;
    wc_d      = wc_q;
    z_out_d   = 2'b00;
    z_valid_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      // done_q marks the cycle just after FLUSH; a start there is dropped
      IDLE: if (start && !done_q) begin
        state_d = LOAD;
        j_d     = '0;
        q_d     = '0;
        qm_d    = {2{QM_INIT}};
        ws_d    = '0;
        wc_d    = '0;
      end
      LOAD:  if (in_valid && j_q == J_LAST_L) state_d = FLUSH;
      FLUSH: if (j_q == J_LAST_F) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (step) begin
      j_d  = j_q + 1'b1;
      ws_d = stg_Ws_out;
      wc_d = stg_Wc_out;
      q_d  = q_nxt;
      qm_d = qm_nxt;
      if (j_q >= J_DELTA) begin
        z_out_d   = stg_z;
        z_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      j_q       <= '0;
      q_q       <= '0;
      qm_q      <= {2{QM_INIT}};
      ws_q      <= '0;
      wc_q      <= '0;
      z_out_q   <= 2'b00;
      z_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      q_q       <= q_d;
      qm_q      <= qm_d;
      ws_q      <= ws_d;
      wc_q      <= wc_d;
      z_out_q   <= z_out_d;
      z_valid_q <= z_valid_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_om_seq_ctrl.sv
// Directed bench for om_seq_ctrl with a behavioural multiplier stage that keeps
// the whole residual in {Ws,Wc} as one 24-bit integer in units of 2^-11.

module tb_om_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready;
  logic [1:0]  x_in, y_in, z_out, stg_x, stg_y, stg_z;
  logic        z_valid, busy, done;
  logic [8:0]  stg_xY_in, stg_yX_in;
  logic [11:0] stg_Ws_in, stg_Wc_in, stg_Ws_out, stg_Wc_out;

  int n_chk = 0;
  int n_fail = 0;

  om_seq_ctrl #(.WL_XY(8), .DELTA(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .x_in(x_in), .y_in(y_in), .z_out(z_out),
    .z_valid(z_valid), .busy(busy), .done(done), .stg_x(stg_x),
    .stg_y(stg_y), .stg_xY_in(stg_xY_in), .stg_yX_in(stg_yX_in),
    .stg_Ws_in(stg_Ws_in), .stg_Wc_in(stg_Wc_in), .stg_z(stg_z),
    .stg_Ws_out(stg_Ws_out), .stg_Wc_out(stg_Wc_out)
  );

  always #5 clk = ~clk;

  function automatic int dec(input logic [1:0] d);
    return (d == 2'b10) ? 1 : (d == 2'b01) ? -1 : 0;
  endfunction

  // v = 2w + x*Y[j+1] + y*X[j] (already scaled by 2^-3 via units); select at +-1/2.
  int          w, v, wn;
  logic [23:0] wb;
  always_comb begin
    w  = $signed({stg_Ws_in, stg_Wc_in});
    v  = 2 * w + dec(stg_x) * int'($signed(stg_xY_in)) + dec(stg_y) * int'($signed(stg_yX_in));
    wn = v;
    stg_z = 2'b00;
    if (v >= 1024) begin
      stg_z = 2'b10;
      wn = v - 2048;
    end else if (v < -1024) begin
      stg_z = 2'b01;
      wn = v + 2048;
    end
    wb = wn[23:0];
    stg_Ws_out = wb[23:12];
    stg_Wc_out = wb[11:0];
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is 1 time unit after an edge in IDLE; this cycle is cycle 0.
  task automatic run_op(input string nm, input logic [15:0] xs, input logic [15:0] ys,
                        input logic [15:0] zexp, input int zval, input int stall_len,
                        input int exp_done, input logic [8:0] xexp, input logic [8:0] yexp,
                        input bit start_in_load, input bit start_at_done);
    logic [15:0] zs;
    int cyc, k, stall, nz, dcyc, zint;
    bit got_done;
    zs = '0; cyc = 0; k = 0; stall = 0; nz = 0; dcyc = -1; got_done = 0;
    start = 1'b1;
    in_valid = 1'b0;
    while (!got_done && cyc < 40) begin
      tick();
      cyc++;
      start = start_in_load && (cyc == 2);
      if (z_valid) begin
        if (nz < 8) zs[15-2*nz -: 2] = z_out;
        nz++;
      end
      if (done) begin
        got_done = 1;
        dcyc = cyc;
        chk({nm, "_busy_at_done"}, busy, 0);
        chk({nm, "_x_final"}, stg_yX_in, xexp);
        chk({nm, "_y_final"}, stg_xY_in, yexp);
        start = start_at_done;
      end
      if (k < 8 && !(k == 3 && stall < stall_len)) begin
        in_valid = 1'b1;
        x_in = xs[15-2*k -: 2];
        y_in = ys[15-2*k -: 2];
        chk({nm, "_in_ready"}, in_ready, 1);
        k++;
      end else begin
        in_valid = 1'b0;
        x_in = 2'b10;
        y_in = 2'b01;
        if (k == 3 && stall < stall_len) begin
          chk({nm, "_stall_ready"}, in_ready, 1);
          stall++;
        end
      end
    end
    in_valid = 1'b0;
    chk({nm, "_done_seen"}, got_done, 1);
    chk({nm, "_done_cycle"}, dcyc, exp_done);
    chk({nm, "_z_count"}, nz, 8);
    chk({nm, "_z_digits"}, zs, zexp);
    zint = 0;
    for (int i = 0; i < 8; i++) zint += dec(zs[15-2*i -: 2]) * (1 << (7 - i));
    chk({nm, "_z_accuracy"}, (zint - zval <= 1 && zval - zint <= 1), 1);
    tick();
    start = 1'b0;
    chk({nm, "_idle_after"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b0; x_in = 2'b00; y_in = 2'b00;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_z_valid", z_valid, 0);
    chk("rst_z_out", z_out, 0);
    chk("rst_stg_xy", {stg_x, stg_y}, 0);
    chk("rst_stg_xY", stg_xY_in, 0);
    chk("rst_stg_yX", stg_yX_in, 0);
    chk("rst_stg_w", {stg_Ws_in, stg_Wc_in}, 0);
    rst_n = 1'b1; start = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // 0.5 * 0.75 = 0.375: z = +1,0,-1,0...
    run_op("pos", 16'h8000, 16'hA000, 16'h8400, 96, 0, 12, 9'h080, 9'h0C0, 0, 0);
    // 0.375 * -0.375 = -0.140625: z = 0,-1,+1,0,0,-1,0,0
    run_op("neg", 16'h9800, 16'h4800, 16'h1810, -36, 0, 12, 9'h060, 9'h1A0, 0, 0);
    run_op("stall", 16'h8000, 16'hA000, 16'h8400, 96, 2, 14, 9'h080, 9'h0C0, 0, 0);
    run_op("proto", 16'h8000, 16'hA000, 16'h8400, 96, 0, 12, 9'h080, 9'h0C0, 1, 1);
    // starts one cycle after done; 11 digits behave as 00
    run_op("d11", 16'hBFFF, 16'hAFFF, 16'h8400, 96, 0, 12, 9'h080, 9'h0C0, 0, 0);

    // reset during FLUSH (cycle 10) discards the operation
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
      in_valid = (c <= 8);
      x_in = 2'b10;
      y_in = 2'b10;
      if (c == 10) rst_n = 1'b0;
    end
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_z_valid", z_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_w", {stg_Ws_in, stg_Wc_in}, 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    begin
      int saw_done;
      saw_done = 0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (done || z_valid) saw_done = 1;
      end
      chk("mid_rst_quiet", saw_done, 0);
    end
    run_op("post_rst", 16'h9800, 16'h4800, 16'h1810, -36, 0, 12, 9'h060, 9'h1A0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
